mdu: RTL and testbench

Multiply/divide unit with HI/LO registers, sitting beside the ALU in the execute stage of the MIPS datapath and consumed by it for `mfhi`/`mflo` reads. Accepts one operation per start pulse, computes mult/div over a fixed multi-cycle latency while signalling `busy`, and writes HI/LO at completion. The controller stalls any later MDU instruction while `start | busy` is high.

---
 rtl/mdu.sv | 170 +++++++++++++++++
 tb/tb_mdu.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu - multiply/divide unit with HI/LO registers for the MIPS execute stage.
//
// One operation is accepted per start pulse while idle. mult/multu/div/divu
// (and madd/maddu when MDU_MADD_EN is defined) compute their 64-bit result
// at the accept edge into a staging pair, then hold busy for a fixed
// latency and commit staging into HI/LO on the edge where busy falls.
// mthi/mtlo write HI/LO directly in one cycle without raising busy.
//
// Handshake: start is sampled only on edges where busy==0; a start seen
// while busy==1 is dropped entirely (including mthi/mtlo), so the
// controller keeps the instruction stalled while start|busy is high.
//
// Parameters:
//   MULT_CYCLES  busy length for mult/multu/madd/maddu (1..31)
//   DIV_CYCLES   busy length for div/divu (1..31)
// Build macro:
//   MDU_MADD_EN  when defined, ops 6/7 are madd/maddu; otherwise no-ops.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-low reset
//   start    single-cycle request
//   op       0 mult,1 multu,2 div,3 divu,4 mthi,5 mtlo,6 madd,7 maddu
//   rs_data  operand A / mthi-mtlo source
//   rt_data  operand B
//   busy     operation in flight
//   hi, lo   HI/LO registers
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] shi_q, shi_d;
  logic [31:0] slo_q, slo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  // Cleared for divide-by-zero so completion leaves HI/LO untouched.
  logic        wr_q, wr_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        quo_s, rem_s, quo_u, rem_u;
  logic               div_zero;

  assign prod_s   = $signed({{32{rs_data[31]}}, rs_data}) *
                    $signed({{32{rt_data[31]}}, rt_data});
  assign prod_u   = {32'd0, rs_data} * {32'd0, rt_data};
  assign div_zero = (rt_data == 32'd0);

  // Divider results. The most-negative / -1 case overflows a 32-bit signed
  // quotient, so it is pinned to the architected wrap result explicitly.
  always_comb begin
    quo_s = 32'd0;
    rem_s = 32'd0;
    quo_u = 32'd0;
    rem_u = 32'd0;
    if (!div_zero) begin
      quo_u = rs_data / rt_data;
      rem_u = rs_data % rt_data;
      if (rs_data == 32'h8000_0000 && rt_data == 32'hFFFF_FFFF) begin
        quo_s = 32'h8000_0000;
        rem_s = 32'd0;
      end else begin
        quo_s = $signed(rs_data) / $signed(rt_data);
        rem_s = $signed(rs_data) % $signed(rt_data);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shi_d   = shi_q;
    slo_d   = slo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    wr_d    = wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (op)
            3'd0: begin
              {shi_d, slo_d} = prod_s;
              wr_d = 1'b1; cnt_d = 5'(MULT_CYCLES); state_d = S_RUN;
            end
            3'd1: begin
              {shi_d, slo_d} = prod_u;
              wr_d = 1'b1; cnt_d = 5'(MULT_CYCLES); state_d = S_RUN;
            end
            3'd2: begin
              {shi_d, slo_d} = {rem_s, quo_s};
              wr_d = !div_zero; cnt_d = 5'(DIV_CYCLES); state_d = S_RUN;
            end
            3'd3: begin
              {shi_d, slo_d} = {rem_u, quo_u};
              wr_d = !div_zero; cnt_d = 5'(DIV_CYCLES); state_d = S_RUN;
            end
            3'd4: hi_d = rs_data;
            3'd5: lo_d = rs_data;
`ifdef MDU_MADD_EN
            // Addend is HI/LO as they stand at the accept edge.
            3'd6: begin
              {shi_d, slo_d} = {hi_q, lo_q} + 64'(prod_s);
              wr_d = 1'b1; cnt_d = 5'(MULT_CYCLES); state_d = S_RUN;
            end
            3'd7: begin
              {shi_d, slo_d} = {hi_q, lo_q} + prod_u;
              wr_d = 1'b1; cnt_d = 5'(MULT_CYCLES); state_d = S_RUN;
            end
`else
            3'd6, 3'd7: ;
`endif
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (cnt_q == 5'd1) begin
          if (wr_q) begin
            hi_d = shi_q;
            lo_d = slo_q;
          end
          cnt_d   = 5'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      shi_q   <= 32'd0;
      slo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      wr_q    <= wr_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu - directed bench for mdu. A behavioural model computes HI/LO/busy
// from the arithmetic definition of each op and the accept/complete edge
// numbers; a compare process checks the DUT against it every cycle, and
// directed cases pin hand-computed literal results and busy lengths.
module tb_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .hi(hi), .lo(lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  int          edge_n = 0;
  int          done_e = 0;
  bit          m_busy = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] p_res;
  bit          p_wr;
  longint      sa, sb, sq, sr;

  always @(posedge clk) begin
    edge_n++;
    if (!reset) begin
      m_hi = 0; m_lo = 0; m_busy = 0;
    end else if (m_busy) begin
      if (edge_n == done_e) begin
        if (p_wr) {m_hi, m_lo} = p_res;
        m_busy = 0;
      end
    end else if (start) begin
      sa = longint'($signed(rs_data));
      sb = longint'($signed(rt_data));
      case (op)
        3'd0: begin p_res = 64'(sa * sb); p_wr = 1; m_busy = 1; done_e = edge_n + MC; end
        3'd1: begin p_res = {32'd0, rs_data} * {32'd0, rt_data}; p_wr = 1; m_busy = 1; done_e = edge_n + MC; end
        3'd2: begin
          p_wr = (rt_data != 0);
          if (p_wr) begin sq = sa / sb; sr = sa % sb; p_res = {sr[31:0], sq[31:0]}; end
          m_busy = 1; done_e = edge_n + DC;
        end
        3'd3: begin
          p_wr = (rt_data != 0);
          if (p_wr) p_res = {rs_data % rt_data, rs_data / rt_data};
          m_busy = 1; done_e = edge_n + DC;
        end
        3'd4: m_hi = rs_data;
        3'd5: m_lo = rs_data;
`ifdef MDU_MADD_EN
        3'd6: begin p_res = {m_hi, m_lo} + 64'(sa * sb); p_wr = 1; m_busy = 1; done_e = edge_n + MC; end
        3'd7: begin p_res = {m_hi, m_lo} + {32'd0, rs_data} * {32'd0, rt_data}; p_wr = 1; m_busy = 1; done_e = edge_n + MC; end
`endif
        default: ;
      endcase
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
    end
  end

  // driver tasks
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int n);
    start = 1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    while (busy && n < 64) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 64) chk("busy_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 64) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 64) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  int n;

  initial begin
    reset = 0; start = 0; op = 0; rs_data = 0; rt_data = 0;
    @(posedge clk); #1;
    chk_en = 1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    // start during reset is ignored
    start = 1; op = 3'd0; rs_data = 32'hFFFF_FFFF; rt_data = 32'd2;
    @(posedge clk); #1;
    start = 0;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    chk("rst_start_lo", lo, 32'd0);
    reset = 1;
    @(posedge clk); #1;

    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, n);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, n);
    chk("div_negdiv_lo", lo, 32'hFFFF_FFFD);
    chk("div_negdiv_hi", hi, 32'd1);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("divu_lo", lo, 32'd0);
    chk("divu_hi", hi, 32'h8000_0000);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);

    // divide by zero leaves HI/LO
    run_op(3'd4, 32'h1111_1111, 32'd0, n);
    chk("mthi_cycles", 32'(n), 32'd0);
    run_op(3'd5, 32'h2222_2222, 32'd0, n);
    chk("mthi_hi", hi, 32'h1111_1111);
    run_op(3'd2, 32'd5, 32'd0, n);
    chk("div0_cycles", 32'(n), 32'd10);
    chk("div0_hi", hi, 32'h1111_1111);
    chk("div0_lo", lo, 32'h2222_2222);
    run_op(3'd3, 32'd9, 32'd0, n);
    chk("divu0_lo", lo, 32'h2222_2222);

    // mtlo on cycle 2 of RUN is dropped
    start = 1; op = 3'd0; rs_data = 32'd3; rt_data = 32'd4;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    start = 1; op = 3'd5; rs_data = 32'h0000_DEAD;
    @(posedge clk); #1;
    start = 0;
    wait_idle();
    chk("ignore_lo", lo, 32'h0000_000C);
    chk("ignore_hi", hi, 32'd0);
    run_op(3'd5, 32'h0000_DEAD, 32'd0, n);
    chk("mtlo_after", lo, 32'h0000_DEAD);

    // mtlo held through the completion edge is dropped too
    start = 1; op = 3'd1; rs_data = 32'd5; rt_data = 32'd6;
    @(posedge clk); #1;
    op = 3'd5; rs_data = 32'h0000_BEEF;
    repeat (MC) begin @(posedge clk); #1; end
    start = 0;
    chk("b2b_busy", {31'd0, busy}, 32'd0);
    chk("b2b_lo", lo, 32'd30);

    // abort on reset mid-RUN
    run_op(3'd4, 32'h0000_AAAA, 32'd0, n);
    run_op(3'd5, 32'h0000_BBBB, 32'd0, n);
    start = 1; op = 3'd2; rs_data = 32'd100; rt_data = 32'd7;
    @(posedge clk); #1;
    start = 0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (DC) begin @(posedge clk); #1; end
    chk("abort_stay_lo", lo, 32'd0);

    // madd / maddu
    run_op(3'd4, 32'd0, 32'd0, n);
    run_op(3'd5, 32'hFFFF_FFFF, 32'd0, n);
    run_op(3'd7, 32'd1, 32'd1, n);
`ifdef MDU_MADD_EN
    chk("maddu_cycles", 32'(n), 32'd5);
    chk("maddu_hi", hi, 32'd1);
    chk("maddu_lo", lo, 32'd0);
`else
    chk("maddu_cycles", 32'(n), 32'd0);
    chk("maddu_hi", hi, 32'd0);
    chk("maddu_lo", lo, 32'hFFFF_FFFF);
`endif
    run_op(3'd6, 32'hFFFF_FFFF, 32'd3, n);
`ifdef MDU_MADD_EN
    chk("madd_hi", hi, 32'd0);
    chk("madd_lo", lo, 32'hFFFF_FFFD);
`else
    chk("madd_hi", hi, 32'd0);
    chk("madd_lo", lo, 32'hFFFF_FFFF);
`endif

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
